// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer: FSM states,
// base opcodes and PC source select.
package rv_ctrl_pkg;

  typedef logic [2:0] ctrl_state_t;

  localparam ctrl_state_t S_IDLE   = 3'd0;
  localparam ctrl_state_t S_FETCH  = 3'd1;
  localparam ctrl_state_t S_DECODE = 3'd2;
  localparam ctrl_state_t S_EXEC   = 3'd3;
  localparam ctrl_state_t S_MEM    = 3'd4;
  localparam ctrl_state_t S_WB     = 3'd5;
  localparam ctrl_state_t S_HALT   = 3'd6;
  localparam ctrl_state_t S_TRAP   = 3'd7;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PCSEL_SEQ  = 2'd0;
  localparam logic [1:0] PCSEL_TGT  = 2'd1;
  localparam logic [1:0] PCSEL_JALR = 2'd2;

endpackage

// File: rtl/rv_opcode_class.sv
// Combinational opcode classifier: maps ir[6:0] onto the instruction classes
// the sequencer branches on.
module rv_opcode_class
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jal,
  output logic       is_jalr,
  output logic       is_sys,
  output logic       illegal
);

  logic is_alu;

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_sys    = (opcode == OPC_SYSTEM);
  assign is_alu    = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) ||
                     (opcode == OPC_LUI) || (opcode == OPC_AUIPC);

  assign illegal = !(is_load || is_store || is_branch || is_jal || is_jalr ||
                     is_sys || is_alu);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// RV32I multi-cycle control sequencer: fetch handshake, IR, decode, and
// ALU/MEM/WB/PC sequencing. RV_CTRL_PERF_CNT_EN enables the cycle/instret counters.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 0,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  output logic             ir_we,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic             br_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  ctrl_state_t   state, nxt;
  logic [TW-1:0] wcnt;
  logic          alu_wait;
  logic          timeout;
  logic          is_load, is_store, is_branch, is_jal, is_jalr, is_sys, illegal;
  ctrl_state_t   after_retire;

  rv_opcode_class u_cls (
    .opcode    (ir[6:0]),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .is_sys    (is_sys),
    .illegal   (illegal)
  );

  // wcnt counts cycles spent in the current state; only FETCH/MEM consult it
  assign timeout      = (BUS_TIMEOUT != 0) && (wcnt == TO_LAST);
  assign after_retire = run ? S_FETCH : S_IDLE;

  always_comb begin
    nxt       = state;
    ir_we     = 1'b0;
    alu_start = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PCSEL_SEQ;
    case (state)
      S_IDLE:   if (run) nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (timeout) begin
          nxt = S_TRAP;
        end
      end
      S_DECODE: begin
        if (is_sys)       nxt = S_HALT;
        else if (illegal) nxt = S_TRAP;
        else              nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_start = !alu_wait;
        if (alu_done) begin
          if (is_load || is_store) begin
            nxt = S_MEM;
          end else if (is_branch) begin
            pc_we  = 1'b1;
            pc_sel = br_taken ? PCSEL_TGT : PCSEL_SEQ;
            nxt    = after_retire;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (is_store) begin
            pc_we = 1'b1;
            nxt   = after_retire;
          end else begin
            nxt = S_WB;
          end
        end else if (timeout) begin
          nxt = S_TRAP;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        pc_sel = is_jal ? PCSEL_TGT : (is_jalr ? PCSEL_JALR : PCSEL_SEQ);
        nxt    = after_retire;
      end
      S_HALT:  nxt = S_HALT;
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_IDLE;
    endcase
  end

  assign imem_req = (state == S_FETCH);
  assign dmem_req = (state == S_MEM);
  assign dmem_we  = (state == S_MEM) && is_store;
  assign halted   = (state == S_HALT) || (state == S_TRAP);
  assign trap     = (state == S_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ir       <= '0;
      wcnt     <= '0;
      alu_wait <= 1'b0;
    end else begin
      state    <= nxt;
      alu_wait <= (state == S_EXEC) && (nxt == S_EXEC);
      wcnt     <= (nxt != state) ? '0 : wcnt + TW'(1);
      if (ir_we) ir <= imem_rdata;
    end
  end

`ifdef RV_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ret_q;
  logic             active;

  assign active = !((state == S_IDLE) || (state == S_HALT) || (state == S_TRAP));

  // every retirement coincides with its final pc_we
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (active) cyc_q <= cyc_q + CNT_W'(1);
      if (pc_we)  ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cyc_q;
  assign instret   = ret_q;
`else
  assign cycle_cnt = '0;
  assign instret   = '0;
`endif

endmodule
